// File: rtl/servo_pwm_sched_pkg.sv
// servo_pkg: shared types and widths for the servo PWM frame scheduler.
//   state_t   - scheduler FSM state (RUN, COMMIT_L, COMMIT_R)
//   CH_LEFT / CH_RIGHT - values of pos_ch selecting a channel
//   POS_W / CNT_W      - position and frame-counter widths
package servo_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        COMMIT_L = 2'd1,
        COMMIT_R = 2'd2
    } state_t;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    localparam int POS_W = 10;
    localparam int CNT_W = 12;

endpackage

// File: rtl/servo_pwm_sched_if.sv
// Position-command channel from the SPI front end.
//   pos_valid - command valid (master)
//   pos_ready - command accepted on a cycle where pos_valid & pos_ready (slave)
//   pos_ch    - target channel, CH_LEFT / CH_RIGHT (master)
//   pos_data  - requested position (master)
// Handshake: the master holds pos_ch/pos_data stable while pos_valid is high
// and pos_ready is low; a transfer happens on every rising clk edge where
// both pos_valid and pos_ready are high, and pos_valid may stay high for
// back-to-back transfers.
interface servo_pwm_sched_if;
    import servo_pkg::*;

    logic             pos_valid;
    logic             pos_ready;
    logic             pos_ch;
    logic [POS_W-1:0] pos_data;

    modport master (output pos_valid, output pos_ch, output pos_data, input pos_ready);
    modport slave  (input pos_valid, input pos_ch, input pos_data, output pos_ready);

endinterface

// File: rtl/servo_pwm_sched_timer.sv
// servo_frame_timer: tick prescaler plus the shared PWM frame counter.
//   clk, rst     - system clock, synchronous active-high reset
//   enable       - run counting; low clears and holds everything at 0
//   cntr_val     - frame counter, 0..PERIOD_TICKS-1, advances once per tick
//   frame_start  - one-cycle pulse in the first cycle cntr_val is 0 after a wrap
module servo_frame_timer
    import servo_pkg::*;
#(
    parameter int DIV          = 100,
    parameter int PERIOD_TICKS = 3000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [CNT_W-1:0] cntr_val,
    output logic             frame_start
);
    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [PW-1:0]    presc_q;
    logic [CNT_W-1:0] cntr_q;
    logic             fs_q;
    logic             tick;
    logic             wrap;

    assign tick = (presc_q == PW'(DIV - 1));
    assign wrap = tick && (cntr_q == CNT_W'(PERIOD_TICKS - 1));

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            presc_q <= '0;
            cntr_q  <= '0;
            fs_q    <= 1'b0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                cntr_q <= wrap ? '0 : cntr_q + 1'b1;
            end
            // Registered alongside the wrap so it lines up with cntr_val == 0.
            fs_q <= wrap;
        end
    end

    assign cntr_val    = cntr_q;
    assign frame_start = fs_q;

endmodule

// File: rtl/servo_pwm_sched.sv
// servo_pwm_sched: frame scheduler and configuration controller for the
// left/right servo PWM comparators.
//   clk, rst     - system clock, synchronous active-high reset
//   enable       - run frame generation; low forces duty outputs to 0
//   pos_if       - position command channel (slave side)
//   cntr_val     - shared frame counter to the comparators
//   duty_left    - left compare threshold (MIN_PULSE + committed position)
//   duty_right   - right compare threshold
//   frame_start  - one-cycle pulse at the frame wrap
//   sat_err      - one-cycle pulse after accepting pos_data > MAX_POS
//   state_dbg    - current scheduler state
// Commands land in target registers at any time; they only move cur/duty in
// the COMMIT_L/COMMIT_R cycles right after frame_start, slew-limited.
module servo_pwm_sched
    import servo_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int TICK_HZ      = 1_000_000,
    parameter int PERIOD_TICKS = 3000,
    parameter int MIN_PULSE    = 1000,
    parameter int MAX_POS      = 1000,
    parameter int SLEW_STEP    = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    servo_pwm_sched_if.slave    pos_if,
    output logic [CNT_W-1:0]    cntr_val,
    output logic [CNT_W-1:0]    duty_left,
    output logic [CNT_W-1:0]    duty_right,
    output logic                frame_start,
    output logic                sat_err,
    output state_t              state_dbg
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam logic [POS_W-1:0] MID_POS  = POS_W'(MAX_POS / 2);
    localparam logic [CNT_W-1:0] MID_DUTY = CNT_W'(MIN_PULSE + MAX_POS / 2);
    localparam logic signed [POS_W:0] STEP_S = (POS_W + 1)'(SLEW_STEP);

    state_t           state_q, state_d;
    logic [POS_W-1:0] target_l_q, target_r_q, cur_l_q, cur_r_q;
    logic [CNT_W-1:0] duty_l_q, duty_r_q;
    logic             sat_err_q;
    logic             accept;
    logic             over;
    logic [POS_W-1:0] clamped;
    logic [POS_W-1:0] cur_l_nxt, cur_r_nxt;

    servo_frame_timer #(
        .DIV          (DIV),
        .PERIOD_TICKS (PERIOD_TICKS)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cntr_val    (cntr_val),
        .frame_start (frame_start)
    );

    // Move cur toward tgt by at most SLEW_STEP; d is the signed 11-bit difference.
    function automatic logic [POS_W-1:0] slew(input logic [POS_W-1:0] tgt,
                                              input logic [POS_W-1:0] cur);
        logic signed [POS_W:0] d;
        d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (d > STEP_S)       slew = cur + POS_W'(SLEW_STEP);
        else if (d < -STEP_S) slew = cur - POS_W'(SLEW_STEP);
        else                  slew = tgt;
    endfunction

    assign pos_if.pos_ready = !rst && (state_q == RUN);
    assign accept  = pos_if.pos_valid && pos_if.pos_ready;
    assign over    = (pos_if.pos_data > POS_W'(MAX_POS));
    assign clamped = over ? POS_W'(MAX_POS) : pos_if.pos_data;

    assign cur_l_nxt = slew(target_l_q, cur_l_q);
    assign cur_r_nxt = slew(target_r_q, cur_r_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (frame_start) state_d = COMMIT_L;
            COMMIT_L: state_d = COMMIT_R;
            COMMIT_R: state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            target_l_q <= MID_POS;
            target_r_q <= MID_POS;
            cur_l_q    <= MID_POS;
            cur_r_q    <= MID_POS;
            duty_l_q   <= MID_DUTY;
            duty_r_q   <= MID_DUTY;
            sat_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sat_err_q <= accept && over;
            // Accepts only happen in RUN, so they never collide with a commit.
            if (accept) begin
                if (pos_if.pos_ch == CH_LEFT) target_l_q <= clamped;
                else                          target_r_q <= clamped;
            end
            if (state_q == COMMIT_L) begin
                cur_l_q  <= cur_l_nxt;
                duty_l_q <= CNT_W'(MIN_PULSE) + {{(CNT_W - POS_W){1'b0}}, cur_l_nxt};
            end
            if (state_q == COMMIT_R) begin
                cur_r_q  <= cur_r_nxt;
                duty_r_q <= CNT_W'(MIN_PULSE) + {{(CNT_W - POS_W){1'b0}}, cur_r_nxt};
            end
        end
    end

    // Disabled: comparators see threshold 0 and drive low; registers are kept.
    assign duty_left  = enable ? duty_l_q : '0;
    assign duty_right = enable ? duty_r_q : '0;
    assign sat_err    = sat_err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_servo_pwm_sched.sv
// Directed bench for servo_pwm_sched. DIV = 4 (CLK_HZ=400, TICK_HZ=100);
// the frame is shortened to 250 ticks (1000 clk) so the 25-frame slew run
// stays short. Outputs are sampled on the falling clock edge.
module tb_servo_pwm_sched;
    import servo_pkg::*;

    localparam int PERIOD = 250;
    localparam int FRAME_CLK = PERIOD * 4;

    logic             clk;
    logic             rst;
    logic             enable;
    logic [CNT_W-1:0] cntr_val;
    logic [CNT_W-1:0] duty_left;
    logic [CNT_W-1:0] duty_right;
    logic             frame_start;
    logic             sat_err;
    state_t           state_dbg;

    servo_pwm_sched_if pos_if ();

    servo_pwm_sched #(
        .CLK_HZ       (400),
        .TICK_HZ      (100),
        .PERIOD_TICKS (PERIOD),
        .MIN_PULSE    (1000),
        .MAX_POS      (1000),
        .SLEW_STEP    (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pos_if      (pos_if),
        .cntr_val    (cntr_val),
        .duty_left   (duty_left),
        .duty_right  (duty_right),
        .frame_start (frame_start),
        .sat_err     (sat_err),
        .state_dbg   (state_dbg)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;
    int last_cntr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges and land on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Step at least once, then until frame_start is seen (bounded).
    task automatic wait_fs(input string tag, output int cycles);
        cycles = 0;
        do begin
            last_cntr = int'(cntr_val);
            step(1);
            cycles++;
        end while (frame_start !== 1'b1 && cycles < FRAME_CLK + 100);
        check_eq({tag, "_fs_seen"}, 32'(frame_start), 32'd1);
    endtask

    task automatic wait_cntr(input int val);
        int n;
        n = 0;
        while (int'(cntr_val) != val && n < FRAME_CLK + 100) begin
            step(1);
            n++;
        end
        check_eq("wait_cntr", 32'(cntr_val), 32'(val));
    endtask

    // Drive one command and check the sat_err pulse that follows it.
    task automatic send(input logic ch, input logic [POS_W-1:0] data, input logic exp_sat);
        int n;
        pos_if.pos_valid = 1'b1;
        pos_if.pos_ch    = ch;
        pos_if.pos_data  = data;
        n = 0;
        while (pos_if.pos_ready !== 1'b1 && n < 10) begin
            step(1);
            n++;
        end
        check_eq("send_ready", 32'(pos_if.pos_ready), 32'd1);
        step(1);
        pos_if.pos_valid = 1'b0;
        check_eq("sat_err_pulse", 32'(sat_err), 32'(exp_sat));
        step(1);
        check_eq("sat_err_clear", 32'(sat_err), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        pos_if.pos_valid = 1'b0;
        pos_if.pos_ch = 1'b0;
        pos_if.pos_data = '0;
        step(3);

        // reset state
        check_eq("rst_ready", 32'(pos_if.pos_ready), 32'd0);
        check_eq("rst_cntr", 32'(cntr_val), 32'd0);
        check_eq("rst_duty_l_dis", 32'(duty_left), 32'd0);
        check_eq("rst_state", 32'(state_dbg), 32'(RUN));
        check_eq("rst_fs", 32'(frame_start), 32'd0);
        check_eq("rst_sat", 32'(sat_err), 32'd0);
        rst = 1'b0;
        step(1);
        check_eq("ready_after_rst", 32'(pos_if.pos_ready), 32'd1);

        // 1. counting, wrap, frame period
        enable = 1'b1;
        step(3);
        check_eq("cntr_before_tick", 32'(cntr_val), 32'd0);
        step(1);
        check_eq("cntr_first_tick", 32'(cntr_val), 32'd1);
        check_eq("duty_l_init", 32'(duty_left), 32'd1500);
        check_eq("duty_r_init", 32'(duty_right), 32'd1500);
        wait_fs("f1", cyc);
        check_eq("first_fs_cycles", 32'(cyc), 32'(FRAME_CLK - 4));
        check_eq("cntr_at_fs", 32'(cntr_val), 32'd0);
        check_eq("cntr_before_wrap", 32'(last_cntr), 32'(PERIOD - 1));
        wait_fs("f2", cyc);
        check_eq("frame_period", 32'(cyc), 32'(FRAME_CLK));
        step(1);
        check_eq("fs_one_cycle", 32'(frame_start), 32'd0);
        check_eq("state_commit_l", 32'(state_dbg), 32'(COMMIT_L));

        // 2. left write mid-frame, committed at the next wrap
        step(100);
        send(CH_LEFT, 10'd520, 1'b0);
        step(10);
        check_eq("duty_l_hold", 32'(duty_left), 32'd1500);
        wait_fs("f3", cyc);
        step(1);
        check_eq("duty_l_in_commit_l", 32'(duty_left), 32'd1500);
        step(1);
        check_eq("duty_l_commit", 32'(duty_left), 32'd1520);
        check_eq("state_commit_r", 32'(state_dbg), 32'(COMMIT_R));
        step(1);
        check_eq("duty_r_unchanged", 32'(duty_right), 32'd1500);
        check_eq("state_run", 32'(state_dbg), 32'(RUN));

        // 3. right slews 500 -> 1000 in 20-step frames, then holds
        step(50);
        send(CH_RIGHT, 10'd1000, 1'b0);
        for (int k = 1; k <= 26; k++) begin
            wait_fs("slew", cyc);
            step(3);
            check_eq($sformatf("slew_r_%0d", k), 32'(duty_right),
                     32'((1500 + 20 * k > 2000) ? 2000 : 1500 + 20 * k));
        end
        check_eq("duty_l_steady", 32'(duty_left), 32'd1520);

        // 4. over-range write clamps and flags
        step(20);
        send(CH_LEFT, 10'd1023, 1'b1);
        wait_fs("f4", cyc);
        step(3);
        check_eq("clamp_step", 32'(duty_left), 32'd1540);

        // 5. valid held across frame_start; frame_start-cycle write wins
        wait_cntr(PERIOD - 2);
        pos_if.pos_valid = 1'b1;
        pos_if.pos_ch = CH_RIGHT;
        pos_if.pos_data = 10'd700;
        cyc = 0;
        while (frame_start !== 1'b1 && cyc < 20) begin
            step(1);
            cyc++;
        end
        check_eq("fs_hold_seen", 32'(frame_start), 32'd1);
        check_eq("ready_at_fs", 32'(pos_if.pos_ready), 32'd1);
        pos_if.pos_data = 10'd980;
        step(1);
        check_eq("ready_low_1", 32'(pos_if.pos_ready), 32'd0);
        step(1);
        check_eq("ready_low_2", 32'(pos_if.pos_ready), 32'd0);
        check_eq("duty_l_frame5", 32'(duty_left), 32'd1560);
        step(1);
        check_eq("ready_back", 32'(pos_if.pos_ready), 32'd1);
        check_eq("duty_r_fs_write", 32'(duty_right), 32'd1980);
        pos_if.pos_valid = 1'b0;

        // 6. disable mid-frame, re-enable, reset during COMMIT_L
        wait_cntr(170);
        enable = 1'b0;
        step(1);
        check_eq("dis_cntr", 32'(cntr_val), 32'd0);
        check_eq("dis_duty_l", 32'(duty_left), 32'd0);
        check_eq("dis_duty_r", 32'(duty_right), 32'd0);
        step(5);
        check_eq("dis_cntr_hold", 32'(cntr_val), 32'd0);
        check_eq("dis_fs", 32'(frame_start), 32'd0);
        enable = 1'b1;
        step(1);
        check_eq("reen_cntr", 32'(cntr_val), 32'd0);
        check_eq("reen_duty_l", 32'(duty_left), 32'd1560);
        check_eq("reen_duty_r", 32'(duty_right), 32'd1980);
        wait_fs("f6", cyc);
        check_eq("reen_fs_cycles", 32'(cyc), 32'(FRAME_CLK - 1));
        step(1);
        check_eq("pre_rst_state", 32'(state_dbg), 32'(COMMIT_L));
        rst = 1'b1;
        step(1);
        check_eq("rst_duty_l", 32'(duty_left), 32'd1500);
        check_eq("rst_duty_r", 32'(duty_right), 32'd1500);
        check_eq("rst_state_run", 32'(state_dbg), 32'(RUN));
        check_eq("rst_cntr_mid", 32'(cntr_val), 32'd0);
        check_eq("rst_ready_mid", 32'(pos_if.pos_ready), 32'd0);
        rst = 1'b0;
        step(1);
        check_eq("ready_after_rst2", 32'(pos_if.pos_ready), 32'd1);
        wait_fs("f7", cyc);
        check_eq("post_rst_fs_cycles", 32'(cyc), 32'(FRAME_CLK - 1));
        step(3);
        check_eq("post_rst_duty_l", 32'(duty_left), 32'd1500);
        check_eq("post_rst_duty_r", 32'(duty_right), 32'd1500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
